// File: rtl/alu_iter.sv
// Registered, handshaked ALU: single-cycle logic/arith ops plus
// iterative shift-add multiply and restoring divide over WIDTH steps.
module alu_iter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] w,
  output logic             zero,
  output logic             less_greater,
  output logic             illegal
);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLT   = 4'b0101;
  localparam logic [3:0] OP_SLTU  = 4'b0110;
  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] OP_MULHU = 4'b1001;
  localparam logic [3:0] OP_DIVU  = 4'b1010;
  localparam logic [3:0] OP_REMU  = 4'b1011;

  typedef enum logic {
    S_IDLE,
    S_CALC
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_iop;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_w;
  logic             r_zero;
  logic             r_lg;
  logic             r_illegal;
  logic             r_done;
  logic             r_busy;

  logic [WIDTH-1:0] w_sc_res;
  logic             w_sc_ill;
  logic             w_is_iter;

  logic [WIDTH:0]   w_madd;
  logic [WIDTH:0]   w_dsh;
  logic [WIDTH-1:0] w_dsub;
  logic             w_dok;
  logic [WIDTH-1:0] w_nhi;
  logic [WIDTH-1:0] w_nlo;
  logic [WIDTH-1:0] w_it_res;

  // Decode the incoming op into a single-cycle result or an iterative launch
  always_comb begin
    w_sc_res  = '0;
    w_sc_ill  = 1'b0;
    w_is_iter = 1'b0;
    unique case (1'b1)
      (op == OP_ADD):   w_sc_res = a + b;
      (op == OP_SUB):   w_sc_res = a - b;
      (op == OP_AND):   w_sc_res = a & b;
      (op == OP_OR):    w_sc_res = a | b;
      (op == OP_XOR):   w_sc_res = a ^ b;
      (op == OP_SLT):
        w_sc_res = {{(WIDTH-1){1'b0}},
                    ($signed(a) < $signed(b))};
      (op == OP_SLTU):
        w_sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
      (op == OP_MUL),
      (op == OP_MULHU),
      (op == OP_DIVU),
      (op == OP_REMU):  w_is_iter = 1'b1;
      default:          w_sc_ill = 1'b1;
    endcase
  end

  // One iteration step: shift-add multiply or restoring divide
  always_comb begin
    w_madd = {1'b0, r_hi}
           + (r_lo[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
    w_dsh  = {r_hi, r_lo[WIDTH-1]};
    w_dok  = (w_dsh >= {1'b0, r_opb});
    w_dsub = w_dsh[WIDTH-1:0] - r_opb;
    if (r_iop[1]) begin
      w_nhi = w_dok ? w_dsub : w_dsh[WIDTH-1:0];
      w_nlo = {r_lo[WIDTH-2:0], w_dok};
    end else begin
      w_nhi = w_madd[WIDTH:1];
      w_nlo = {w_madd[0], r_lo[WIDTH-1:1]};
    end
    w_it_res = r_iop[0] ? w_nhi : w_nlo;
  end

  // Control FSM with registered result, flags and handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_iop     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_opb     <= '0;
      r_w       <= '0;
      r_zero    <= 1'b1;
      r_lg      <= 1'b0;
      r_illegal <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_is_iter) begin
              r_state <= S_CALC;
              r_busy  <= 1'b1;
              r_cnt   <= CNT_W'(WIDTH);
              r_iop   <= op[1:0];
              r_hi    <= '0;
              r_lo    <= a;
              r_opb   <= b;
            end else begin
              r_w       <= w_sc_res;
              r_zero    <= (w_sc_res == '0);
              r_lg      <= (w_sc_res != '0);
              r_illegal <= w_sc_ill;
              r_done    <= 1'b1;
            end
          end
        end
        S_CALC: begin
          r_hi  <= w_nhi;
          r_lo  <= w_nlo;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_w       <= w_it_res;
            r_zero    <= (w_it_res == '0);
            r_lg      <= (w_it_res != '0);
            r_illegal <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign w            = r_w;
  assign zero         = r_zero;
  assign less_greater = r_lg;
  assign illegal      = r_illegal;

endmodule

// File: tb/tb_alu_iter.sv
// Directed and random checks of alu_iter against an arithmetic
// reference model, with latency, hold and reset-abort checks.
module tb_alu_iter;

  localparam int W  = 16;
  localparam int CW = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] w;
  logic         zero;
  logic         less_greater;
  logic         illegal;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] last_w;

  alu_iter #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .op(op),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .w(w),
    .zero(zero),
    .less_greater(less_greater),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [3:0] o,
                                input logic [W-1:0] x,
                                input logic [W-1:0] y,
                                output logic [W-1:0] r,
                                output logic ill);
    longint unsigned p;
    p   = longint'(x) * longint'(y);
    ill = 1'b0;
    r   = '0;
    case (o)
      4'd0:  r = x + y;
      4'd1:  r = x - y;
      4'd2:  r = x & y;
      4'd3:  r = x | y;
      4'd4:  r = x ^ y;
      4'd5:  r = ($signed(x) < $signed(y)) ? 1 : 0;
      4'd6:  r = (x < y) ? 1 : 0;
      4'd8:  r = p[W-1:0];
      4'd9:  r = p[2*W-1:W];
      4'd10: r = (y == 0) ? '1 : x / y;
      4'd11: r = (y == 0) ? x : x % y;
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic check_out(input string tag,
                           input logic [W-1:0] ew,
                           input logic eill);
    chk({tag, ".w"}, w, ew);
    chk({tag, ".zero"}, W'(zero), W'(ew == 0));
    chk({tag, ".lg"}, W'(less_greater), W'(ew != 0));
    chk({tag, ".illegal"}, W'(illegal), W'(eill));
  endtask

  // Drives a single-cycle op and checks it one cycle later.
  // Leaves start high so calls chain back-to-back.
  task automatic single(input string tag, input logic [3:0] o,
                        input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r;
    logic ill;
    model(o, x, y, r, ill);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".done"}, W'(done), W'(1));
    chk({tag, ".busy"}, W'(busy), W'(0));
    check_out(tag, r, ill);
    last_w = r;
  endtask

  task automatic run_iter(input string tag, input logic [3:0] o,
                          input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit poke);
    logic [W-1:0] r;
    logic ill;
    int lat;
    int bcnt;
    model(o, x, y, r, ill);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    op = 4'($urandom);
    lat = 1;
    bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      if (lat == 3) chk({tag, ".hold"}, w, last_w);
      if (poke && lat == 5) begin
        op = 4'd0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk({tag, ".latency"}, W'(lat), W'(W + 1));
    chk({tag, ".busycnt"}, W'(bcnt), W'(W));
    chk({tag, ".busy_at_done"}, W'(busy), W'(0));
    check_out(tag, r, ill);
    last_w = r;
  endtask

  initial begin
    logic [3:0]   ro;
    logic [W-1:0] rx;
    logic [W-1:0] ry;

    rst = 1'b1; start = 1'b1; op = 4'd0; a = 1; b = 1;
    last_w = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", W'(busy), W'(0));
    chk("rst.done", W'(done), W'(0));
    check_out("rst", '0, 1'b0);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("idle.done", W'(done), W'(0));

    single("add", 4'd0, 16'h7FFF, 16'h0001);
    single("sub", 4'd1, 16'd5, 16'd5);
    single("slt", 4'd5, 16'hFFFF, 16'h0001);
    single("sltu", 4'd6, 16'hFFFF, 16'h0001);
    single("xor", 4'd4, 16'hF0F0, 16'hFFFF);
    start = 1'b0;
    @(posedge clk); #1;
    chk("b2b.done_drop", W'(done), W'(0));
    chk("b2b.hold", w, last_w);

    run_iter("mul", 4'd8, 16'd300, 16'd300, 1'b1);
    run_iter("mulhu", 4'd9, 16'd300, 16'd300, 1'b0);
    run_iter("divu", 4'd10, 16'd1000, 16'd7, 1'b1);
    run_iter("remu", 4'd11, 16'd1000, 16'd7, 1'b0);
    run_iter("divu0", 4'd10, 16'h1234, 16'd0, 1'b0);
    run_iter("remu0", 4'd11, 16'h1234, 16'd0, 1'b0);

    single("ill", 4'b1111, 16'd3, 16'd4);
    single("add_after_ill", 4'd0, 16'd1, 16'd1);
    start = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      ro = 4'($urandom_range(0, 15));
      rx = W'($urandom);
      ry = (i % 4 == 0) ? '0 : W'($urandom);
      if (ro[3] && !ro[2]) begin
        run_iter("rnd_iter", ro, rx, ry, i[0]);
      end else begin
        single("rnd_single", ro, rx, ry);
        start = 1'b0;
        @(posedge clk); #1;
      end
    end

    op = 4'd10; a = 16'd1000; b = 16'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("abort.busy_before", W'(busy), W'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort.busy", W'(busy), W'(0));
    chk("abort.done", W'(done), W'(0));
    check_out("abort", '0, 1'b0);
    rst = 1'b0;
    last_w = '0;
    run_iter("mul_after_rst", 4'd8, 16'd3, 16'd4, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
